instr_loader: RTL and testbench

- Write-side counterpart of the CPU's instruction memory read port: the CPU only reads instrmem by PC; this block writes it.
- Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port at sequential word addresses.
- Holds the CPU in reset (cpu_rst) until a complete program has been loaded.

---
 rtl/instr_loader_pkg.sv | 22 ++
 rtl/instr_loader_word_assembler.sv | 40 ++++
 rtl/instr_loader.sv | 174 +++++++++++++++++
 tb/tb_instr_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader and the instruction memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CKSUM,
        S_DONE
    } loader_state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_STEP  = 4;

    // Reset vector of the CPU; instrmem maps its first word here as well.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words, lane 0 first.
// Latency: word_full/word_next are combinational on the 4th accepted byte.
// Backpressure: none of its own; shift_en is only raised on an accepted byte.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  idx;
    logic [31:0] word;

    // Current partial word with the incoming byte merged into its lane.
    always_comb begin
        word_next = word;
        word_next[{idx, 3'b000} +: 8] = byte_in;
        word_full = shift_en && (idx == 2'(WORD_BYTES - 1));
    end

    // Lane index and partial word; index wraps to 0 after the last lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (shift_en) begin
            idx  <= idx + 2'd1;
            word <= word_next;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds cpu_rst until done (INSTR_LOADER_CKSUM_EN adds a trailing XOR checksum byte).
// Latency: one WRITE cycle per word after its 4th byte; done one edge after the last byte or write.
// Backpressure: byte_ready is low in IDLE, WRITE and DONE; bytes are only consumed on byte_valid && byte_ready.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
    parameter int                    CNT_WIDTH  = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  err
);

    loader_state_t        state;
    logic [CNT_WIDTH-1:0] len;
    logic [CNT_WIDTH-1:0] len_full;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 last_word;
    logic                 byte_xfer;
    logic                 load_go;
    logic                 asm_shift;
    logic [31:0]          asm_word;
    logic                 asm_full;

`ifdef INSTR_LOADER_CKSUM_EN
    logic [7:0] cksum;
`else
    assign err = 1'b0;
`endif

    // Handshake, start qualification and the extra-width last-word compare.
    always_comb begin
        byte_xfer = byte_valid && byte_ready;
        load_go   = start && ((state == S_IDLE) || (state == S_DONE));
        asm_shift = byte_xfer && (state == S_DATA);
        len_full  = CNT_WIDTH'({byte_in, len[7:0]});
        cnt_inc   = (CNT_WIDTH + 1)'(word_cnt) + 1'b1;
        last_word = (cnt_inc == {1'b0, len});
    end

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (load_go),
        .shift_en  (asm_shift),
        .byte_in   (byte_in),
        .word_next (asm_word),
        .word_full (asm_full)
    );

    // Load sequencer with registered handshake, memory and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wd     <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_cnt   <= '0;
            len        <= '0;
`ifdef INSTR_LOADER_CKSUM_EN
            err        <= 1'b0;
            cksum      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
`ifdef INSTR_LOADER_CKSUM_EN
            if (byte_xfer && (state != S_CKSUM))
                cksum <= cksum ^ byte_in;
`endif
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LEN_LO;
                        byte_ready <= 1'b1;
                        mem_addr   <= BASE_ADDR;
                        cpu_rst    <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        word_cnt   <= '0;
`ifdef INSTR_LOADER_CKSUM_EN
                        err        <= 1'b0;
                        cksum      <= '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (byte_xfer) begin
                        len   <= CNT_WIDTH'(byte_in);
                        state <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (byte_xfer) begin
                        len <= len_full;
                        if (len_full != '0) begin
                            state <= S_DATA;
                        end else begin
`ifdef INSTR_LOADER_CKSUM_EN
                            state      <= S_CKSUM;
`else
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            cpu_rst    <= 1'b0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (asm_full) begin
                        state      <= S_WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_wd     <= DATA_WIDTH'(asm_word);
                    end
                end
                S_WRITE: begin
                    mem_addr <= mem_addr + ADDR_WIDTH'(ADDR_STEP);
                    word_cnt <= cnt_inc[CNT_WIDTH-1:0];
                    if (!last_word) begin
                        state      <= S_DATA;
                        byte_ready <= 1'b1;
                    end else begin
`ifdef INSTR_LOADER_CKSUM_EN
                        state      <= S_CKSUM;
                        byte_ready <= 1'b1;
`else
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        cpu_rst    <= 1'b0;
`endif
                    end
                end
`ifdef INSTR_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (byte_xfer) begin
                        state      <= S_DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        err        <= (byte_in != cksum);
                        cpu_rst    <= (byte_in != cksum);
                    end
                end
`endif
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a stream-level model predicts every memory write and the final status.
// Latency: n/a.
// Backpressure: byte_valid is driven with random gaps and honoured against byte_ready.
module tb_instr_loader;

`ifdef INSTR_LOADER_CKSUM_EN
    localparam bit CKSUM_ON = 1'b1;
`else
    localparam bit CKSUM_ON = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;
    logic        err;

    always #5 clk = ~clk;

    instr_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt),
        .err        (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state: program words, byte stream, expected writes and status.
    logic [31:0] prog[$];
    logic [7:0]  stream[$];
    logic [63:0] exp_q[$];
    int          exp_total = 0;
    int          wr_seen   = 0;
    logic        exp_err   = 1'b0;

    task automatic model_load(input bit use_bad, input logic [7:0] bad_val);
        int          n;
        logic [7:0]  x;
        logic [7:0]  tail;
        logic [31:0] w;
        n = prog.size();
        x = 8'h00;
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        for (int k = 0; k < n; k++) begin
            w = prog[k];
            for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
            exp_q.push_back({BASE + 32'(4 * k), w});
            exp_total++;
        end
        foreach (stream[i]) x = x ^ stream[i];
        tail    = use_bad ? bad_val : x;
        exp_err = CKSUM_ON && (tail != x);
        if (CKSUM_ON) stream.push_back(tail);
    endtask

    // Every write pulse is matched against the model's next expected write.
    always @(negedge clk) begin
        if (rst && mem_we === 1'b1) begin
            wr_seen++;
            check("wr_ready_low", byte_ready, 1'b0);
            if (exp_q.size() > 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[63:32]);
                check("wr_data", mem_wd, e[31:0]);
            end else begin
                check("wr_extra", wr_seen, exp_total);
            end
        end
    end

    task automatic send(input int max_bytes, input int duty, input bit poke);
        int idx   = 0;
        int guard = 0;
        bit xfer;
        while (idx < stream.size() && idx < max_bytes && guard < 20000) begin
            byte_in    = stream[idx];
            byte_valid = ($urandom_range(99) < duty);
            start      = poke && ($urandom_range(9) == 0);
            xfer       = byte_valid && byte_ready;
            @(posedge clk);
            if (xfer) idx++;
            guard++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        if (guard >= 20000) check("send_timeout", idx, stream.size());
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_load(input string tag, input int duty, input bit poke, input int bound);
        int c = 0;
        pulse_start();
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_rst_held"}, cpu_rst, 1'b1);
        check({tag, "_done_clr"}, done, 1'b0);
        send(32'h7fff_ffff, duty, poke);
        while (done !== 1'b1 && c < bound) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_cpu_rst"}, cpu_rst, exp_err);
        check({tag, "_word_cnt"}, word_cnt, prog.size());
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        check({tag, "_wr_count"}, wr_seen, exp_total);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, byte_ready, 1'b0);
        check({tag, "_we"}, mem_we, 1'b0);
        check({tag, "_addr"}, mem_addr, BASE);
        check({tag, "_wd"}, mem_wd, 32'h0);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_cnt"}, word_cnt, 16'h0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        int base_seen;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_cpu_rst", cpu_rst, 1'b1);
            check("idle_ready", byte_ready, 1'b0);
            check("idle_we", mem_we, 1'b0);
            check("idle_done", done, 1'b0);
        end

        // Two-word program, back-to-back bytes, then with gaps and stray starts.
        prog = '{32'h0050_0093, 32'h0010_0513};
        model_load(1'b0, 8'h00);
        run_load("two", 100, 1'b0, 10);
        model_load(1'b0, 8'h00);
        run_load("gaps", 50, 1'b1, 10);

        // Empty program.
        prog.delete();
        model_load(1'b0, 8'h00);
        run_load("zero", 100, 1'b0, 3);

        // Random programs; the last one carries a random checksum byte.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 5);
            prog.delete();
            for (int k = 0; k < n; k++) prog.push_back($urandom);
            model_load(r == 3, 8'($urandom));
            run_load("rand", $urandom_range(30, 100), r[0], 10);
        end

        // Reset after 5 of 8 data bytes, then a clean reload from BASE.
        prog = '{32'hDEAD_BEEF, 32'h1234_5678};
        model_load(1'b0, 8'h00);
        base_seen = wr_seen;
        pulse_start();
        send(7, 100, 1'b0);
        check("mid_writes", wr_seen - base_seen, 1);
        rst = 1'b0;
        #1;
        check_reset_values("mid_rst");
        exp_q.delete();
        exp_total = wr_seen;
        @(negedge clk) rst = 1'b1;
        model_load(1'b0, 8'h00);
        run_load("restart", 70, 1'b0, 10);

`ifdef INSTR_LOADER_CKSUM_EN
        // Single-word program with the correct checksum, then with 0x00.
        prog = '{32'h0050_0093};
        model_load(1'b0, 8'h00);
        run_load("ck_good", 100, 1'b0, 10);
        model_load(1'b1, 8'h00);
        run_load("ck_bad", 100, 1'b0, 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
